// File: rtl/fm_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_accel_pkg
//  Description : Shared state encoding and helpers for the backward-search
//                accelerator (sequencer and execution modules).
//  Revision    : 1.0 - initial release
// ============================================================================
package fm_accel_pkg;

    localparam int STATE_W = 3;

    // Sequencer state encoding, shared with the execution modules
    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_GET_PARAM  = 3'd1;
    localparam logic [STATE_W-1:0] ST_GET_DATA_1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_GET_OCC    = 3'd3;
    localparam logic [STATE_W-1:0] ST_EX         = 3'd4;
    localparam logic [STATE_W-1:0] ST_WRITE_BACK = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE       = 3'd6;
    localparam logic [STATE_W-1:0] ST_ERROR      = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE       = ST_IDLE,
        S_GET_PARAM  = ST_GET_PARAM,
        S_GET_DATA_1 = ST_GET_DATA_1,
        S_GET_OCC    = ST_GET_OCC,
        S_EX         = ST_EX,
        S_WRITE_BACK = ST_WRITE_BACK,
        S_DONE       = ST_DONE,
        S_ERROR      = ST_ERROR
    } fm_state_e;

    // A state is "busy" while an iteration is in flight
    function automatic logic is_busy_state(input logic [STATE_W-1:0] s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fm_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : fm_wait_timer
//  Description : Saturating wait counter for the search sequencer. Counts
//                unpaused cycles spent waiting for an external event and
//                flags a timeout on the last allowed cycle when the event
//                has not arrived.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_wait_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,   // state change, stage advance or abort
    input  logic                 hold_i,    // pause: freeze the count
    input  logic                 count_i,   // currently in a waiting state
    input  logic                 event_i,   // awaited event present this cycle
    input  logic [TIMEOUT_W-1:0] limit_i,   // 0 disables the timeout
    output logic                 timeout_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] wait_cnt_q;
    logic [TIMEOUT_W-1:0] wait_cnt_d;
    logic [TIMEOUT_W-1:0] w_limit_m1;
    logic                 w_at_limit;

    assign w_limit_m1 = limit_i - TIMEOUT_W'(1);
    assign w_at_limit = (limit_i != '0) && (wait_cnt_q == w_limit_m1);

    // An event on the limit cycle wins, so the flag requires its absence
    assign timeout_o = count_i && !hold_i && w_at_limit && !event_i;

    // Next count: clear beats hold, hold beats increment, increment saturates
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i) begin
            wait_cnt_d = '0;
        end else if (hold_i) begin
            wait_cnt_d = wait_cnt_q;
        end else if (count_i && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fm_search_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fm_search_state_ctrl
//  Description : Top-level sequencer for the backward-search accelerator.
//                Per iteration: parameter fetch, C/read/D fetch, a
//                configurable number of Occ fetch stages, execute and a
//                multi-cycle write-back. Supports pause, abort, a wait
//                timeout into ERROR, iteration counting and a state-entry
//                strobe for the execution modules.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_search_state_ctrl
    import fm_accel_pkg::*;
#(
    parameter int N_OCC_STAGES = 2,
    parameter int WB_CYCLES    = 1,
    parameter int TIMEOUT_W    = 16,
    parameter int ITER_W       = 32,
    parameter int STG_W        = (N_OCC_STAGES > 1) ? $clog2(N_OCC_STAGES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic                 is_finish,
    input  logic                 is_find,
    input  logic                 need_occ,
    input  logic                 occ_done,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [STATE_W-1:0]   state,
    output logic [STG_W-1:0]     occ_stage,
    output logic                 state_enter,
    output logic [ITER_W-1:0]    iter_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [STATE_W-1:0]   err_state
);

    localparam int              WB_CNT_W = 4;
    localparam logic [STG_W-1:0]    LAST_STG = STG_W'(N_OCC_STAGES - 1);
    localparam logic [WB_CNT_W-1:0] WB_LAST  = WB_CNT_W'(WB_CYCLES - 1);

    fm_state_e             state_q,       state_d;
    logic [STG_W-1:0]      occ_stage_q,   occ_stage_d;
    logic                  state_enter_q, state_enter_d;
    logic [ITER_W-1:0]     iter_count_q,  iter_count_d;
    logic [STATE_W-1:0]    err_state_q,   err_state_d;
    logic [WB_CNT_W-1:0]   wb_cnt_q,      wb_cnt_d;

    logic                  w_busy;
    logic                  w_waiting;
    logic                  w_wait_event;
    logic                  w_wait_clear;
    logic                  w_timeout;
    logic                  w_stage_adv;

    assign w_busy       = is_busy_state(state_q);
    assign w_waiting    = (state_q == S_GET_PARAM) || (state_q == S_GET_OCC);
    assign w_wait_event = (state_q == S_GET_PARAM) ? is_find : occ_done;

    // Any visit boundary restarts the wait window; a pause alone never does
    assign w_wait_clear = abort || (state_d != state_q) || w_stage_adv;

    fm_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (w_wait_clear),
        .hold_i    (pause),
        .count_i   (w_waiting),
        .event_i   (w_wait_event),
        .limit_i   (timeout_limit),
        .timeout_o (w_timeout)
    );

    // Prioritised next-state: abort, pause, finish, timeout, then normal flow
    always_comb begin
        state_d      = state_q;
        occ_stage_d  = occ_stage_q;
        iter_count_d = iter_count_q;
        err_state_d  = err_state_q;
        wb_cnt_d     = wb_cnt_q;
        w_stage_adv  = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            occ_stage_d = '0;
        end else if (pause) begin
            // every register keeps its value
            state_d = state_q;
        end else if (is_finish && w_busy) begin
            state_d = S_DONE;
        end else if (w_timeout) begin
            state_d     = S_ERROR;
            err_state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_GET_PARAM;
                        iter_count_d = '0;
                    end
                end
                S_GET_PARAM: begin
                    if (is_find) begin
                        state_d = S_GET_DATA_1;
                    end
                end
                S_GET_DATA_1: begin
                    if (need_occ) begin
                        state_d     = S_GET_OCC;
                        occ_stage_d = '0;
                    end else begin
                        state_d = S_EX;
                    end
                end
                S_GET_OCC: begin
                    if (occ_done) begin
                        if (occ_stage_q == LAST_STG) begin
                            state_d     = S_EX;
                            occ_stage_d = '0;
                        end else begin
                            occ_stage_d = occ_stage_q + STG_W'(1);
                            w_stage_adv = 1'b1;
                        end
                    end
                end
                S_EX: begin
                    state_d  = S_WRITE_BACK;
                    wb_cnt_d = '0;
                end
                S_WRITE_BACK: begin
                    if (wb_cnt_q == WB_LAST) begin
                        state_d      = S_GET_PARAM;
                        iter_count_d = iter_count_q + ITER_W'(1);
                    end else begin
                        wb_cnt_d = wb_cnt_q + WB_CNT_W'(1);
                    end
                end
                S_ERROR: begin
                    // only abort or reset leaves ERROR
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Entry strobe covers state changes and Occ stage advances alike
        state_enter_d = (state_d != state_q) || w_stage_adv;
    end

    // Sequencer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            occ_stage_q   <= '0;
            state_enter_q <= 1'b0;
            iter_count_q  <= '0;
            err_state_q   <= '0;
            wb_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            occ_stage_q   <= occ_stage_d;
            state_enter_q <= state_enter_d;
            iter_count_q  <= iter_count_d;
            err_state_q   <= err_state_d;
            wb_cnt_q      <= wb_cnt_d;
        end
    end

    assign state       = state_q;
    assign occ_stage   = occ_stage_q;
    assign state_enter = state_enter_q;
    assign iter_count  = iter_count_q;
    assign err_state   = err_state_q;
    assign busy        = w_busy;
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_fm_search_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_search_state_ctrl
//  Description : Scoreboard bench for fm_search_state_ctrl. Stimulus pushes
//                the expected state-entry record (state, stage, iteration,
//                error state, cycle); a monitor pops one on every
//                state_enter strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_search_state_ctrl;
    import fm_accel_pkg::*;

    localparam int N_OCC = 3;
    localparam int WB    = 3;
    localparam int TW    = 8;
    localparam int IW    = 4;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pause = 1'b0;
    logic          is_finish = 1'b0;
    logic          is_find = 1'b0;
    logic          need_occ = 1'b0;
    logic          occ_done = 1'b0;
    logic [TW-1:0] timeout_limit = '0;
    logic [2:0]    state;
    logic [SW-1:0] occ_stage;
    logic          state_enter;
    logic [IW-1:0] iter_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    err_state;

    fm_search_state_ctrl #(
        .N_OCC_STAGES (N_OCC),
        .WB_CYCLES    (WB),
        .TIMEOUT_W    (TW),
        .ITER_W       (IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .pause         (pause),
        .is_finish     (is_finish),
        .is_find       (is_find),
        .need_occ      (need_occ),
        .occ_done      (occ_done),
        .timeout_limit (timeout_limit),
        .state         (state),
        .occ_stage     (occ_stage),
        .state_enter   (state_enter),
        .iter_count    (iter_count),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_state     (err_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] st;
        int         stg;
        int         it;
        int         es;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [2:0] st, input int stg, input int it,
                        input int es, input int c);
        exp_t e;
        e.st = st; e.stg = stg; e.it = it; e.es = es; e.c = c;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: every entry strobe must match the oldest expected record
    always @(negedge clk) begin : mon
        exp_t e;
        logic eb, ed, ee;
        if (rst_n && state_enter) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL enter_unexpected: got state=%0d stg=%0d cyc=%0d, required no entry",
                         state, occ_stage, cyc);
            end else begin
                e = sb.pop_front();
                if (state !== e.st || occ_stage !== SW'(e.stg) || iter_count !== IW'(e.it) ||
                    err_state !== 3'(e.es) || cyc != e.c) begin
                    errors++;
                    $display("FAIL enter_record: got state=%0d stg=%0d iter=%0d es=%0d cyc=%0d, required state=%0d stg=%0d iter=%0d es=%0d cyc=%0d",
                             state, occ_stage, iter_count, err_state, cyc,
                             e.st, e.stg, e.it, e.es, e.c);
                end
                eb = (e.st >= 3'd1) && (e.st <= 3'd5);
                ed = (e.st == 3'd6);
                ee = (e.st == 3'd7);
                checks++;
                if ({busy, done, err} !== {eb, ed, ee}) begin
                    errors++;
                    $display("FAIL decode: got busy/done/err=%b%b%b, required %b%b%b",
                             busy, done, err, eb, ed, ee);
                end
            end
        end
    end

    initial begin
        int c0;
        int c1;
        int exp_it;

        // Reset
        tick(3);
        chk("rst_state", state, 0);
        chk("rst_occ_stage", occ_stage, 0);
        chk("rst_state_enter", state_enter, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_err_state", err_state, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_no_enter", state_enter, 0);

        // Nominal iteration, no Occ: 1,1,2,4,5,5,5,1
        c0 = cyc; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 0, c0 + 1);
        tick(1); start = 1'b0;
        tick(1); is_find = 1'b1;
        push(ST_GET_DATA_1, 0, 0, 0, c0 + 3);
        push(ST_EX,         0, 0, 0, c0 + 4);
        push(ST_WRITE_BACK, 0, 0, 0, c0 + 5);
        push(ST_GET_PARAM,  0, 1, 0, c0 + 8);
        tick(1); is_find = 1'b0;
        tick(5);
        chk("iter_after_nominal", iter_count, 1);

        // Occ path: three stages, occ_done every other cycle
        c0 = cyc; is_find = 1'b1; need_occ = 1'b1;
        push(ST_GET_DATA_1, 0, 1, 0, c0 + 1);
        push(ST_GET_OCC,    0, 1, 0, c0 + 2);
        push(ST_GET_OCC,    1, 1, 0, c0 + 4);
        push(ST_GET_OCC,    2, 1, 0, c0 + 6);
        push(ST_EX,         0, 1, 0, c0 + 8);
        push(ST_WRITE_BACK, 0, 1, 0, c0 + 9);
        push(ST_GET_PARAM,  0, 2, 0, c0 + 12);
        tick(1); is_find = 1'b0;
        tick(1); need_occ = 1'b0;
        tick(1); occ_done = 1'b1;
        tick(1); occ_done = 1'b0;
        tick(1); occ_done = 1'b1;
        tick(1); occ_done = 1'b0;
        tick(1); occ_done = 1'b1;
        tick(1); occ_done = 1'b0;
        tick(4);

        // Pause in GET_OCC stage 1 freezes everything, then Occ timeout
        c0 = cyc; timeout_limit = 8'd6; is_find = 1'b1; need_occ = 1'b1;
        push(ST_GET_DATA_1, 0, 2, 0, c0 + 1);
        push(ST_GET_OCC,    0, 2, 0, c0 + 2);
        push(ST_GET_OCC,    1, 2, 0, c0 + 4);
        push(ST_ERROR,      1, 2, 3, c0 + 15);
        tick(1); is_find = 1'b0;
        tick(1); need_occ = 1'b0;
        tick(1); occ_done = 1'b1;
        tick(1); occ_done = 1'b0;
        tick(2); pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            occ_done = (i == 1);
            tick(1);
            chk("pause_state", state, 3);
            chk("pause_stage", occ_stage, 1);
        end
        occ_done = 1'b0; pause = 1'b0;
        tick(4);
        start = 1'b1; is_finish = 1'b1;
        tick(2);
        start = 1'b0; is_finish = 1'b0;
        chk("error_holds", state, 7);
        chk("error_state_reg", err_state, 3);
        abort = 1'b1;
        push(ST_IDLE, 0, 2, 3, c0 + 18);
        tick(1); abort = 1'b0;

        // GET_PARAM timeout after exactly four cycles
        c0 = cyc; timeout_limit = 8'd4; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 3, c0 + 1);
        push(ST_ERROR,     0, 0, 1, c0 + 5);
        tick(1); start = 1'b0;
        tick(4); abort = 1'b1;
        push(ST_IDLE, 0, 0, 1, c0 + 6);
        tick(1); abort = 1'b0;
        chk("err_state_kept_after_abort", err_state, 1);

        // is_find on the limit cycle wins over the timeout
        c0 = cyc; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 1, c0 + 1);
        tick(1); start = 1'b0;
        tick(3); is_find = 1'b1;
        push(ST_GET_DATA_1, 0, 0, 1, c0 + 5);
        push(ST_EX,         0, 0, 1, c0 + 6);
        push(ST_WRITE_BACK, 0, 0, 1, c0 + 7);
        push(ST_GET_PARAM,  0, 1, 1, c0 + 10);
        tick(1); is_find = 1'b0;
        tick(5);
        chk("limit_cycle_no_err", err, 0);

        // Priorities: abort+finish, finish in IDLE, pause+abort, finish -> DONE
        c1 = cyc; timeout_limit = '0; is_finish = 1'b1; abort = 1'b1;
        push(ST_IDLE, 0, 1, 1, c1 + 1);
        tick(1); abort = 1'b0;
        tick(1); is_finish = 1'b0; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 1, c1 + 3);
        tick(1); start = 1'b0; pause = 1'b1; abort = 1'b1;
        push(ST_IDLE, 0, 0, 1, c1 + 4);
        tick(1); pause = 1'b0; abort = 1'b0; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 1, c1 + 5);
        tick(1); start = 1'b0; is_find = 1'b1;
        push(ST_GET_DATA_1, 0, 0, 1, c1 + 6);
        push(ST_EX,         0, 0, 1, c1 + 7);
        push(ST_WRITE_BACK, 0, 0, 1, c1 + 8);
        push(ST_GET_PARAM,  0, 1, 1, c1 + 11);
        tick(1); is_find = 1'b0;
        tick(5); is_finish = 1'b1;
        push(ST_DONE, 0, 1, 1, c1 + 12);
        tick(3);
        chk("done_holds_with_finish", done, 1);
        is_finish = 1'b0; start = 1'b1;
        push(ST_GET_PARAM, 0, 0, 1, c1 + 15);
        tick(1); start = 1'b0; abort = 1'b1;
        push(ST_IDLE, 0, 0, 1, c1 + 16);
        tick(1); abort = 1'b0;

        // Sixteen back-to-back iterations: iter_count wraps 15 -> 0
        c0 = cyc; start = 1'b1; is_find = 1'b1; exp_it = 0;
        for (int i = 0; i < 16; i++) begin
            push(ST_GET_PARAM,  0, exp_it, 1, c0 + 1 + 6 * i);
            push(ST_GET_DATA_1, 0, exp_it, 1, c0 + 2 + 6 * i);
            push(ST_EX,         0, exp_it, 1, c0 + 3 + 6 * i);
            push(ST_WRITE_BACK, 0, exp_it, 1, c0 + 4 + 6 * i);
            exp_it = (exp_it + 1) % 16;
        end
        push(ST_GET_PARAM, 0, exp_it, 1, c0 + 97);
        tick(1); start = 1'b0;
        tick(96); is_find = 1'b0;
        chk("iter_wrap", iter_count, 0);
        abort = 1'b1;
        push(ST_IDLE, 0, 0, 1, c0 + 98);
        tick(1); abort = 1'b0;
        tick(2);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_search_state_ctrl.md
Name: fm_search_state_ctrl

Overview:
- Top-level sequencer for the backward-search accelerator.
- Steps each iteration through parameter fetch, C/read/D fetch, a configurable number of Occ fetch stages, execute and write-back.
- Adds to the fixed five-phase controller:
  - parametrised Occ stage count and write-back hold length;
  - pause, abort and a wait-timeout to an ERROR state;
  - iteration counting and a state-entry strobe for the execution modules.

Parameters:
- N_OCC_STAGES, 2, number of Occ fetch stages per iteration (legal range 1..16).
- WB_CYCLES, 1, cycles spent in WRITE_BACK (legal range 1..15).
- TIMEOUT_W, 16, width of the wait counter and of timeout_limit.
- ITER_W, 32, width of iter_count.
- STG_W, max(1,$clog2(N_OCC_STAGES)), derived width of occ_stage.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a search. Honoured only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- pause  in  1  freeze state and counters.
- is_finish  in  1  all iterations complete.
- is_find  in  1  parameter fetch found unfinished work.
- need_occ  in  1  sampled in GET_DATA_1. 1 = Occ fetch required.
- occ_done  in  1  current Occ stage finished (single-cycle pulse).
- timeout_limit  in  TIMEOUT_W  maximum wait cycles. 0 disables the timeout.
- state  out  3  current state.
- occ_stage  out  STG_W  index of the active Occ stage.
- state_enter  out  1  high for the first cycle of each state visit.
- iter_count  out  ITER_W  completed write-backs since start.
- busy  out  1  state not in {IDLE, DONE, ERROR}.
- done  out  1  state == DONE.
- err  out  1  state == ERROR.
- err_state  out  3  state in which the timeout fired.

Behaviour:
- Encoding: IDLE=0, GET_PARAM=1, GET_DATA_1=2, GET_OCC=3, EX=4, WRITE_BACK=5, DONE=6, ERROR=7.
- Reset values: state=IDLE, occ_stage=0, state_enter=0, iter_count=0, err_state=0, wait_cnt=0, wb_cnt=0. busy, done and err are combinational decodes of state.
- Each clock, the first matching rule applies:
  1. !rst_n → reset values.
  2. abort → IDLE; occ_stage=0, wait_cnt=0.
  3. pause → hold every register. state_enter=0.
  4. is_finish while busy → DONE.
  5. Timeout → ERROR, err_state=state.
  6. Normal transitions.
- Normal transitions:
  - IDLE: start → GET_PARAM, iter_count=0.
  - GET_PARAM: is_find → GET_DATA_1; else stay.
  - GET_DATA_1: single cycle. need_occ → GET_OCC with occ_stage=0; else → EX.
  - GET_OCC: occ_done with occ_stage<N_OCC_STAGES-1 → occ_stage+1, stay in GET_OCC, state_enter pulses, wait_cnt=0. occ_done on the last stage → EX, occ_stage=0. Otherwise stay.
  - EX: single cycle → WRITE_BACK, wb_cnt=0.
  - WRITE_BACK: on wb_cnt==WB_CYCLES-1 → GET_PARAM and iter_count+1 (wraps at 2^ITER_W); else wb_cnt+1.
  - DONE: start → GET_PARAM, iter_count=0. is_finish held high in DONE is ignored.
  - ERROR: only abort or reset leaves it. start is ignored.
- Timeout:
  - wait_cnt increments each unpaused cycle in GET_PARAM or GET_OCC. It clears on every state change or Occ stage advance.
  - Timeout fires when timeout_limit!=0, wait_cnt==timeout_limit-1 and the awaited event (is_find or occ_done) is absent that cycle.
  - An event arriving on the limit cycle wins over the timeout.
  - wait_cnt saturates and never wraps.
- state_enter is registered: 1 in the cycle after any transition, including an Occ stage advance, else 0. It also pulses on entry to DONE, ERROR and IDLE-via-abort, but not after reset.
- Simultaneous events:
  - abort with is_finish → IDLE.
  - pause with abort → IDLE.
  - start while busy → ignored.
  - is_finish in IDLE or ERROR → ignored.

Decomposition:
- Shared package fm_accel_pkg holds:
  - the state localparams (3-bit encoding above), reused by the execution modules;
  - the STATE_W=3 constant.
- One natural sub-module: fm_wait_timer. It holds wait_cnt, handles clear/enable/pause, and produces the saturating compare and the timeout flag.

Test Plan:
- Nominal, no Occ: start=1 in IDLE, is_find at cycle 3, need_occ=0 → sequence 1,1,2,4,5,1; iter_count=1; state_enter high on each entry.
- Occ path: N_OCC_STAGES=3, need_occ=1, occ_done pulses 2 cycles apart → occ_stage 0,1,2, then EX; three state_enter pulses inside GET_OCC.
- Timeout: timeout_limit=4, is_find never asserted → ERROR exactly 4 cycles after entering GET_PARAM, err_state=1, err=1; start is ignored; abort → IDLE.
- Event on the limit cycle: timeout_limit=4, is_find on the 4th GET_PARAM cycle → GET_DATA_1, no error.
- Pause and priority: pause for 5 cycles mid-GET_OCC → state, occ_stage and wait_cnt frozen; is_finish together with abort → IDLE; is_finish alone → DONE, then start → GET_PARAM with iter_count=0.
- WB_CYCLES=3: WRITE_BACK lasts 3 cycles. After 2^ITER_W iterations with ITER_W=4, iter_count wraps 15→0.
